// File: rtl/uart_pkg.sv
// Shared UART definitions: command opcodes, NAK byte and FSM state encodings.
package uart_pkg;

    typedef enum logic [1:0] {
        OP_READ      = 2'b00,
        OP_WRITE     = 2'b01,
        OP_WRITE_ACK = 2'b10,
        OP_RESERVED  = 2'b11
    } op_e;

    localparam logic [7:0] NAK_BYTE = 8'hFF;

    typedef enum logic {
        StIdle,
        StGetData
    } parse_state_e;

    typedef enum logic [1:0] {
        StTxIdle,
        StSend,
        StWaitLow,
        StWaitHigh
    } tx_state_e;

endpackage

// File: rtl/uart_reg_bank_if.sv
// Byte-level link between UART_Rx/UART_Tx glue (master) and a frame engine (slave).
interface uart_reg_bank_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_empty;

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_empty,
        output tx_data,
        output tx_wr
    );

    modport master (
        output rx_data,
        output rx_valid,
        output tx_empty,
        input  tx_data,
        input  tx_wr
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Sends a preloaded burst of bytes MSB-first to UART_Tx, pacing each byte on a TXE low->high cycle.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 3,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk100,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [8*MAX_BYTES-1:0] load_data,
    input  logic [CNT_W-1:0]       load_count,
    input  logic                   tx_empty,
    output logic [7:0]             tx_data,
    output logic                   tx_wr,
    output logic                   busy
);
    localparam int unsigned ShiftW = 8 * MAX_BYTES;

    tx_state_e          state_q, state_d;
    logic [ShiftW-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         last_q, last_d;

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            state_q <= StTxIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        tx_wr   = 1'b0;
        unique case (state_q)
            StTxIdle: begin
                if (load) begin
                    shift_d = load_data;
                    cnt_d   = load_count;
                    state_d = StSend;
                end
            end
            StSend: begin
                // rst_n gating keeps a reset cycle from leaking one last write pulse
                if (tx_empty && rst_n) begin
                    tx_wr   = 1'b1;
                    last_d  = shift_q[ShiftW-1 -: 8];
                    shift_d = ShiftW'({shift_q, 8'h00});
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!tx_empty) state_d = StWaitHigh;
            end
            StWaitHigh: begin
                if (tx_empty) state_d = (cnt_q == '0) ? StTxIdle : StSend;
            end
            default: state_d = StTxIdle;
        endcase
    end

    assign tx_data = tx_wr ? shift_q[ShiftW-1 -: 8] : last_q;
    assign busy    = (state_q != StTxIdle);

endmodule

// File: rtl/uart_reg_bank.sv
// UART command parser and host-writable register array; responses go out via uart_tx_sequencer.
module uart_reg_bank
    import uart_pkg::*;
#(
    parameter int unsigned REG_NUMBER     = 8,
    parameter int unsigned DATA_BYTES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                               clk100,
    input  logic                               rst_n,
    uart_reg_bank_if.slave                     uart,
    output logic [REG_NUMBER*8*DATA_BYTES-1:0] reg_q,
    output logic [REG_NUMBER-1:0]              wr_strobe,
    output logic                               overrun
);
    localparam int unsigned RegW      = 8 * DATA_BYTES;
    localparam int unsigned BcW       = $clog2(DATA_BYTES + 1);
    localparam int unsigned TmW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RespBytes = DATA_BYTES + 1;
    localparam int unsigned RcW       = $clog2(RespBytes + 1);
    localparam logic [6:0]  RegLimit  = 7'(REG_NUMBER);

    parse_state_e          state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [BcW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [TmW-1:0]        timer_q, timer_d;
    logic [RegW-1:0]       wdata_q, wdata_d;
    logic [RegW-1:0]       regs_q [REG_NUMBER];
    logic [RegW-1:0]       regs_d [REG_NUMBER];
    logic [REG_NUMBER-1:0] strobe_q, strobe_d;
    logic                  overrun_q, overrun_d;

    logic                  seq_load;
    logic [8*RespBytes-1:0] seq_data;
    logic [RcW-1:0]        seq_count;
    logic                  seq_busy;

    logic                  rx_take;
    logic                  rx_addr_ok;
    logic                  cmd_addr_ok;
    logic [RegW-1:0]       rd_word;
    logic [RegW-1:0]       wr_word;

    assign rx_take     = uart.rx_valid && !seq_busy;
    assign rx_addr_ok  = {1'b0, uart.rx_data[5:0]} < RegLimit;
    assign cmd_addr_ok = {1'b0, cmd_q[5:0]} < RegLimit;
    assign wr_word     = RegW'({wdata_q, uart.rx_data});

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < int'(REG_NUMBER); k++) begin
            if (uart.rx_data[5:0] == 6'(k)) rd_word = regs_q[k];
        end
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            byte_cnt_q <= '0;
            timer_q    <= '0;
            wdata_q    <= '0;
            strobe_q   <= '0;
            overrun_q  <= 1'b0;
            for (int k = 0; k < int'(REG_NUMBER); k++) regs_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            byte_cnt_q <= byte_cnt_d;
            timer_q    <= timer_d;
            wdata_q    <= wdata_d;
            strobe_q   <= strobe_d;
            overrun_q  <= overrun_d;
            for (int k = 0; k < int'(REG_NUMBER); k++) regs_q[k] <= regs_d[k];
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        byte_cnt_d = byte_cnt_q;
        timer_d    = timer_q;
        wdata_d    = wdata_q;
        regs_d     = regs_q;
        strobe_d   = '0;
        overrun_d  = overrun_q | (uart.rx_valid && seq_busy);
        seq_load   = 1'b0;
        seq_data   = '0;
        seq_count  = '0;
        unique case (state_q)
            StIdle: begin
                if (rx_take) begin
                    unique case (op_e'(uart.rx_data[7:6]))
                        OP_READ: begin
                            seq_load = 1'b1;
                            if (rx_addr_ok) begin
                                seq_data  = {uart.rx_data, rd_word};
                                seq_count = RcW'(RespBytes);
                            end else begin
                                seq_data  = {NAK_BYTE, {RegW{1'b0}}};
                                seq_count = RcW'(1);
                            end
                        end
                        OP_WRITE, OP_WRITE_ACK: begin
                            cmd_d      = uart.rx_data;
                            byte_cnt_d = '0;
                            timer_d    = '0;
                            state_d    = StGetData;
                        end
                        default: ;
                    endcase
                end
            end
            StGetData: begin
                if (rx_take) begin
                    timer_d    = '0;
                    wdata_d    = wr_word;
                    byte_cnt_d = byte_cnt_q + BcW'(1);
                    if (byte_cnt_q == BcW'(DATA_BYTES - 1)) begin
                        state_d = StIdle;
                        for (int k = 0; k < int'(REG_NUMBER); k++) begin
                            if (cmd_addr_ok && cmd_q[5:0] == 6'(k)) begin
                                regs_d[k]   = wr_word;
                                strobe_d[k] = 1'b1;
                            end
                        end
                        if (op_e'(cmd_q[7:6]) == OP_WRITE_ACK) begin
                            seq_load  = 1'b1;
                            seq_data  = {(cmd_addr_ok ? cmd_q : NAK_BYTE), {RegW{1'b0}}};
                            seq_count = RcW'(1);
                        end
                    end
                end else if (timer_q >= TmW'(TIMEOUT_CYCLES - 1)) begin
                    // TIMEOUT_CYCLES idle cycles seen: drop the partial frame
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TmW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    uart_tx_sequencer #(
        .MAX_BYTES (RespBytes),
        .CNT_W     (RcW)
    ) u_tx_seq (
        .clk100     (clk100),
        .rst_n      (rst_n),
        .load       (seq_load),
        .load_data  (seq_data),
        .load_count (seq_count),
        .tx_empty   (uart.tx_empty),
        .tx_data    (uart.tx_data),
        .tx_wr      (uart.tx_wr),
        .busy       (seq_busy)
    );

    always_comb begin
        for (int k = 0; k < int'(REG_NUMBER); k++) reg_q[k*RegW +: RegW] = regs_q[k];
    end

    assign wr_strobe = strobe_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed and randomized frames against a frame-level register/response model of uart_reg_bank.
module tb_uart_reg_bank;
    localparam int TIMEOUT = 20;

    logic         clk100;
    logic         rst_n;
    logic [127:0] reg_q;
    logic [7:0]   wr_strobe;
    logic         overrun;

    uart_reg_bank_if bus ();

    uart_reg_bank #(
        .REG_NUMBER     (8),
        .DATA_BYTES     (2),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk100    (clk100),
        .rst_n     (rst_n),
        .uart      (bus),
        .reg_q     (reg_q),
        .wr_strobe (wr_strobe),
        .overrun   (overrun)
    );

    int         checks = 0;
    int         errors = 0;
    logic [15:0] model_regs [8];
    logic [7:0] exp_q [$];
    logic [7:0] last_tx = 8'h00;
    bit         pend = 0;
    bit         txm_busy = 0;

    initial begin
        clk100 = 1'b0;
        forever #5 clk100 = ~clk100;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int k = 0; k < 8; k++) f[k*16 +: 16] = model_regs[k];
        return f;
    endfunction

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || txm_busy) && n < 400) begin
            step();
            n++;
        end
        chk("response_drained", exp_q.size(), 0);
        exp_q.delete();
        idle(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        last_tx = 8'h00;
        for (int k = 0; k < 8; k++) model_regs[k] = 16'h0000;
    endtask

    // One complete frame; expectations come from the command's meaning, not the parser's states.
    task automatic do_frame(input logic [1:0] op, input logic [5:0] addr,
                            input logic [15:0] data, input int gap);
        logic [7:0] cmd;
        logic [7:0] s;
        bit ok;
        int a;
        cmd = {op, addr};
        a = int'(addr);
        ok = (a < 8);
        s = ok ? (8'h01 << a) : 8'h00;
        if (op == 2'd0) begin
            if (ok) begin
                exp_q.push_back(cmd);
                exp_q.push_back(model_regs[a][15:8]);
                exp_q.push_back(model_regs[a][7:0]);
            end else begin
                exp_q.push_back(8'hFF);
            end
            send_byte(cmd);
            @(negedge clk100);
            chk("read_first_txwr", bus.tx_wr, 1);
        end else if (op == 2'd3) begin
            send_byte(cmd);
            @(negedge clk100);
            chk("reserved_no_tx", bus.tx_wr, 0);
        end else begin
            send_byte(cmd);
            idle(gap);
            send_byte(data[15:8]);
            idle(gap);
            if (op == 2'd2) exp_q.push_back(ok ? cmd : 8'hFF);
            if (ok) model_regs[a] = data;
            send_byte(data[7:0]);
            @(negedge clk100);
            chk("commit_strobe", wr_strobe, s);
            chk("commit_reg_q", reg_q, model_flat());
            chk("write_reply_txwr", bus.tx_wr, (op == 2'd2));
            step();
            @(negedge clk100);
            chk("strobe_one_cycle", wr_strobe, 0);
        end
        step();
        wait_done();
        chk("reg_q_after_frame", reg_q, model_flat());
    endtask

    // UART_Tx stand-in: after each write, TXE may linger high briefly, then dips low for a while.
    initial begin
        bus.tx_empty = 1'b1;
        forever begin
            @(negedge clk100);
            if (bus.tx_wr === 1'b1) begin
                txm_busy = 1;
                step();
                idle($urandom_range(0, 2));
                bus.tx_empty = 1'b0;
                idle($urandom_range(1, 3));
                bus.tx_empty = 1'b1;
                txm_busy = 0;
            end
        end
    end

    // Byte monitor: every write pulse must be expected, ready, and preceded by a TXE low phase.
    initial begin
        forever begin
            @(negedge clk100);
            if (bus.tx_empty === 1'b0) pend = 0;
            if (bus.tx_wr === 1'b1) begin
                chk("tx_wr_needs_txe", bus.tx_empty, 1);
                chk("tx_wr_after_txe_cycle", pend, 0);
                pend = 1;
                chk("tx_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("tx_byte", bus.tx_data, exp_q.pop_front());
                last_tx = bus.tx_data;
            end else if (rst_n === 1'b1) begin
                chk("tx_data_hold", bus.tx_data, last_tx);
            end
        end
    end

    initial begin
        int n;
        logic [15:0] rv;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst_n        = 1'b0;
        for (int k = 0; k < 8; k++) model_regs[k] = 16'h0000;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk100);
        chk("reset_reg_q", reg_q, 0);
        chk("reset_wr_strobe", wr_strobe, 0);
        chk("reset_tx_wr", bus.tx_wr, 0);
        chk("reset_tx_data", bus.tx_data, 0);
        chk("reset_overrun", overrun, 0);
        step();

        do_frame(2'd1, 6'd3, 16'hBEEF, 0);
        do_frame(2'd0, 6'd3, 16'h0000, 0);
        do_frame(2'd2, 6'd5, 16'h1234, 1);
        do_frame(2'd2, 6'd10, 16'h0000, 0);
        do_frame(2'd0, 6'd12, 16'h0000, 0);

        // Gap of exactly TIMEOUT idle cycles drops the partial write
        send_byte(8'h41);
        send_byte(8'hAA);
        idle(TIMEOUT);
        exp_q.push_back(8'h01);
        exp_q.push_back(model_regs[1][15:8]);
        exp_q.push_back(model_regs[1][7:0]);
        send_byte(8'h01);
        @(negedge clk100);
        chk("timeout_read_txwr", bus.tx_wr, 1);
        chk("timeout_no_commit", reg_q, model_flat());
        step();
        wait_done();

        // One cycle short of the timeout keeps the frame alive
        send_byte(8'h42);
        send_byte(8'h11);
        idle(TIMEOUT - 1);
        model_regs[2] = 16'h1122;
        send_byte(8'h22);
        @(negedge clk100);
        chk("near_timeout_strobe", wr_strobe, 8'h04);
        chk("near_timeout_reg_q", reg_q, model_flat());
        step();
        wait_done();

        chk("overrun_before", overrun, 0);
        exp_q.push_back(8'h03);
        exp_q.push_back(model_regs[3][15:8]);
        exp_q.push_back(model_regs[3][7:0]);
        send_byte(8'h03);
        idle(2);
        send_byte(8'h00);
        @(negedge clk100);
        chk("overrun_set", overrun, 1);
        step();
        wait_done();
        chk("overrun_sticky", overrun, 1);

        for (int i = 0; i < 30; i++) begin
            rv = 16'($urandom);
            do_frame(2'($urandom_range(0, 3)), 6'($urandom_range(0, 11)), rv,
                     int'($urandom_range(0, 3)));
        end
        chk("overrun_still_set", overrun, 1);

        // Reset in the middle of a READ response
        exp_q.push_back(8'h05);
        exp_q.push_back(model_regs[5][15:8]);
        exp_q.push_back(model_regs[5][7:0]);
        send_byte(8'h05);
        n = 0;
        while (exp_q.size() > 2 && n < 50) begin
            step();
            n++;
        end
        chk("first_byte_before_reset", exp_q.size(), 2);
        do_reset();
        @(negedge clk100);
        chk("rst_reg_q", reg_q, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_tx_wr", bus.tx_wr, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_overrun", overrun, 0);
        step();
        wait_done();

        // Reset in the middle of a WRITE frame; next byte must parse as a command
        send_byte(8'h47);
        send_byte(8'h55);
        do_reset();
        do_frame(2'd0, 6'd7, 16'h0000, 0);
        rv = 16'($urandom);
        do_frame(2'd2, 6'd4, rv, 0);
        do_frame(2'd0, 6'd4, 16'h0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
